// File: rtl/score_glyph_fetch_pkg.sv
// rtl/score_glyph_fetch_pkg.sv - shared constants and FSM encoding for the score glyph fetcher
//
// Purpose : constants shared by the BCD score counter and the glyph fetch engine.
//           SEG_W   - glyph (ROM data) width
//           ADDR_W  - ROM address width
//           DIGIT_W - width of one BCD digit
//           BLANK_CODE - ROM address holding the all-off glyph
//           fetch_state_e - 2-bit fetch FSM encoding
package score_glyph_fetch_pkg;

  localparam int SEG_W   = 10;
  localparam int ADDR_W  = 4;
  localparam int DIGIT_W = 4;

  localparam logic [ADDR_W-1:0] BLANK_CODE = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/score_glyph_fetch_bcd_counter.sv
// rtl/score_glyph_fetch_bcd_counter.sv - saturating decimal ripple counter holding the player score
//
// Purpose : NUM_DIGITS-digit BCD counter. clr has priority over inc; inc at all-9s is ignored.
// Ports   :
//   clk_i        in   system clock
//   rst_n_i      in   asynchronous active-low reset (score -> 0)
//   inc_i        in   add one to the score this cycle
//   clr_i        in   synchronous clear to zero
//   score_bcd_o  out  NUM_DIGITS*DIGIT_W live score, digit 0 (units) in [3:0]
module score_glyph_fetch_bcd_counter
  import score_glyph_fetch_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          inc_i,
  input  logic                          clr_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] score_bcd_o
);

  logic [NUM_DIGITS*DIGIT_W-1:0] score_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] score_d;
  logic                          all_nines;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score_q[i*DIGIT_W +: DIGIT_W] != 4'd9) all_nines = 1'b0;
    end
  end

  // Carry ripples upward through every digit that wraps 9 -> 0; the first
  // digit below 9 absorbs it. Saturation blocks the carry at the source.
  always_comb begin
    logic carry;
    score_d = score_q;
    carry   = inc_i & ~all_nines;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score_q[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          score_d[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          score_d[i*DIGIT_W +: DIGIT_W] = score_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr_i) score_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_bcd_o = score_q;

endmodule

// File: rtl/score_glyph_fetch.sv
// rtl/score_glyph_fetch.sv - score keeper and glyph ROM reader with atomic publish
//
// Purpose : keeps the BCD score and, on refresh, snapshots it and reads one glyph
//           per digit from an external 1-cycle registered ROM into a shadow buffer,
//           then publishes all glyphs in a single edge.
// Ports   :
//   clk_i        in   system clock
//   rst_n_i      in   asynchronous active-low reset
//   score_inc_i  in   +1 to score
//   score_clr_i  in   clear score (wins over inc)
//   refresh_i    in   request a glyph fetch (level sampled)
//   rom_addr_o   out  ADDR_W registered ROM address (0..10)
//   rom_data_i   in   SEG_W ROM glyph, valid the cycle after the ROM sampled the address
//   glyphs_o     out  NUM_DIGITS*SEG_W published glyphs, digit 0 in [SEG_W-1:0]
//   score_bcd_o  out  NUM_DIGITS*4 live BCD score
//   busy_o       out  fetch in progress (ISSUE, CAPTURE, DONE)
//   done_o       out  one-cycle pulse after glyphs were updated
module score_glyph_fetch
  import score_glyph_fetch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_LZ   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          score_inc_i,
  input  logic                          score_clr_i,
  input  logic                          refresh_i,
  output logic [ADDR_W-1:0]             rom_addr_o,
  input  logic [SEG_W-1:0]              rom_data_i,
  output logic [NUM_DIGITS*SEG_W-1:0]   glyphs_o,
  output logic [NUM_DIGITS*DIGIT_W-1:0] score_bcd_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS*DIGIT_W-1:0]        score_bcd;
  fetch_state_e                         state_q;
  logic [IDX_W-1:0]                     idx_q;
  logic [NUM_DIGITS*DIGIT_W-1:0]        snap_q;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     shadow_q;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     glyphs_q;
  logic [ADDR_W-1:0]                    rom_addr_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic                                 pending_q;

  score_glyph_fetch_bcd_counter #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd_counter (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .inc_i       (score_inc_i),
    .clr_i       (score_clr_i),
    .score_bcd_o (score_bcd)
  );

  // ROM address for digit i of a score: the digit itself, or the blank glyph
  // when it is a leading zero. The units digit always shows.
  function automatic logic [ADDR_W-1:0] digit_code(
    input logic [NUM_DIGITS*DIGIT_W-1:0] bcd,
    input int                            i
  );
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= i && bcd[j*DIGIT_W +: DIGIT_W] != '0) upper_zero = 1'b0;
    end
    if (BLANK_LZ != 0 && i > 0 && upper_zero) return BLANK_CODE;
    return ADDR_W'(bcd[i*DIGIT_W +: DIGIT_W]);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      shadow_q   <= '0;
      glyphs_q   <= '0;
      rom_addr_q <= BLANK_CODE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Requests during a fetch collapse into a single follow-up fetch.
      if (refresh_i && state_q != ST_IDLE) pending_q <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (refresh_i || pending_q) begin
            snap_q     <= score_bcd;
            pending_q  <= 1'b0;
            idx_q      <= '0;
            rom_addr_q <= digit_code(score_bcd, 0);
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Address stays put; the ROM registers it at the end of this cycle.
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          shadow_q[idx_q] <= rom_data_i;
          if (int'(idx_q) == NUM_DIGITS - 1) begin
            state_q <= ST_DONE;
          end else begin
            idx_q      <= idx_q + IDX_W'(1);
            rom_addr_q <= digit_code(snap_q, int'(idx_q) + 1);
            state_q    <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          glyphs_q <= shadow_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign glyphs_o    = glyphs_q;
  assign score_bcd_o = score_bcd;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_score_glyph_fetch.sv
// tb/tb_score_glyph_fetch.sv - self-checking bench for score_glyph_fetch with registered glyph ROM
module tb_score_glyph_fetch;
  import score_glyph_fetch_pkg::*;

  localparam int N    = 4;
  localparam int MAXS = 9999;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 score_inc = 1'b0;
  logic                 score_clr = 1'b0;
  logic                 refresh = 1'b0;
  logic [ADDR_W-1:0]    rom_addr;
  logic [SEG_W-1:0]     rom_data;
  logic [N*SEG_W-1:0]   glyphs;
  logic [N*4-1:0]       score_bcd;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_glyph_fetch #(.NUM_DIGITS(N), .BLANK_LZ(1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .score_inc_i (score_inc),
    .score_clr_i (score_clr),
    .refresh_i   (refresh),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .glyphs_o    (glyphs),
    .score_bcd_o (score_bcd),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Glyph ROM: 1-cycle registered read, active-high reset from ~rst_n.
  function automatic logic [SEG_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      4'd0:    return 10'b1111111110;
      4'd1:    return 10'h006;
      4'd2:    return 10'h25B;
      4'd3:    return 10'h14F;
      4'd4:    return 10'h366;
      4'd5:    return 10'h06D;
      4'd6:    return 10'h27D;
      4'd7:    return 10'h107;
      4'd8:    return 10'h37F;
      4'd9:    return 10'h0EF;
      4'd10:   return 10'h000;
      default: return 10'h2AA;
    endcase
  endfunction

  logic             rom_rst;
  logic [SEG_W-1:0] rom_q;
  assign rom_rst  = ~rst_n;
  always @(posedge clk or posedge rom_rst) begin
    if (rom_rst) rom_q <= '0;
    else         rom_q <= rom_word(rom_addr);
  end
  assign rom_data = rom_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: integer score, fetch timeline measured in edges.
  function automatic int pow10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] model_code(input int v, input int i);
    if (i > 0 && v < pow10(i)) return 4'd10;
    return 4'((v / pow10(i)) % 10);
  endfunction

  function automatic logic [N*4-1:0] to_bcd(input int v);
    logic [N*4-1:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  int               m_score = 0;
  int               m_old = 0;
  int               m_phase = 0;
  bit               m_pend = 0;
  int               m_snap = 0;
  logic [3:0]       m_addr = 4'd10;
  logic [N*SEG_W-1:0] m_glyphs = '0;
  bit               m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score = 0; m_phase = 0; m_pend = 0; m_snap = 0;
      m_addr = 4'd10; m_glyphs = '0; m_done = 0;
    end else begin
      m_old = m_score;
      if (score_clr) m_score = 0;
      else if (score_inc && m_score < MAXS) m_score = m_score + 1;
      m_done = 0;
      if (m_phase == 0) begin
        if (refresh || m_pend) begin
          m_pend = 0; m_snap = m_old; m_phase = 1;
        end
      end else begin
        if (refresh) m_pend = 1;
        m_phase = m_phase + 1;
        if (m_phase == 2*N + 2) begin
          for (int i = 0; i < N; i++) m_glyphs[i*SEG_W +: SEG_W] = rom_word(model_code(m_snap, i));
          m_done = 1; m_phase = 0;
        end
      end
      if (m_phase >= 1 && m_phase <= 2*N) m_addr = model_code(m_snap, (m_phase - 1) / 2);
    end
  end

  always @(negedge clk) begin
    chk("score_bcd", 64'(score_bcd), 64'(to_bcd(m_score)));
    chk("rom_addr",  64'(rom_addr),  64'(m_addr));
    chk("busy",      64'(busy),      64'(m_phase != 0));
    chk("done",      64'(done),      64'(m_done));
    chk("glyphs",    64'(glyphs),    64'(m_glyphs));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [35:0] addr_pk;
  int          busy_cyc;

  task automatic fetch(output int lat);
    addr_pk = '0; busy_cyc = 0; lat = 0;
    refresh = 1'b1; tick(1); refresh = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) begin busy_cyc++; addr_pk = {addr_pk[31:0], rom_addr}; end
      if (done) begin lat = k; break; end
    end
    tick(1);
  endtask

  task automatic count_to(input int n);
    score_clr = 1'b1; tick(1); score_clr = 1'b0;
    score_inc = 1'b1; tick(n); score_inc = 1'b0;
  endtask

  int lat;
  int ndone;
  logic [N*SEG_W-1:0] g_first, g_second;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_glyphs", 64'(glyphs), 64'h0);
    chk("rst_addr",   64'(rom_addr), 64'd10);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_score",  64'(score_bcd), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Score 0: units '0', three blanks.
    fetch(lat);
    chk("t1_latency", 64'(lat), 64'd10);
    chk("t1_addrs",   64'(addr_pk), 64'h00AAAAAAA);
    chk("t1_glyphs",  64'(glyphs), 64'h00000003FE);

    // Score 1234.
    count_to(1234);
    chk("t2_score", 64'(score_bcd), 64'h1234);
    fetch(lat);
    chk("t2_addrs",  64'(addr_pk), 64'h443322111);
    chk("t2_busy",   64'(busy_cyc), 64'd9);
    chk("t2_glyphs", 64'(glyphs), 64'({rom_word(4'd1), rom_word(4'd2), rom_word(4'd3), rom_word(4'd4)}));

    // Score 0105: inner zero shown, leading zero blank.
    count_to(105);
    fetch(lat);
    chk("t3_addrs",  64'(addr_pk), 64'h550011AAA);
    chk("t3_glyphs", 64'(glyphs), 64'({10'h000, rom_word(4'd1), rom_word(4'd0), rom_word(4'd5)}));

    // Saturation and clr priority.
    count_to(9998);
    chk("t4_9998", 64'(score_bcd), 64'h9998);
    score_inc = 1'b1; tick(3); score_inc = 1'b0;
    chk("t4_sat", 64'(score_bcd), 64'h9999);
    score_inc = 1'b1; score_clr = 1'b1; tick(1); score_inc = 1'b0; score_clr = 1'b0;
    chk("t4_clr", 64'(score_bcd), 64'h0000);

    // Refresh at 7, inc during fetch, repeated refresh while busy.
    count_to(7);
    refresh = 1'b1; tick(1); refresh = 1'b0;
    tick(2);
    score_inc = 1'b1; tick(1); score_inc = 1'b0;
    refresh = 1'b1; tick(2); refresh = 1'b0;
    ndone = 0; g_first = '0; g_second = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) g_first = glyphs;
        else if (ndone == 1) g_second = glyphs;
        ndone++;
      end
    end
    tick(1);
    chk("t5_ndone",  64'(ndone), 64'd2);
    chk("t5_first",  64'(g_first), 64'({30'h0, rom_word(4'd7)}));
    chk("t5_second", 64'(g_second), 64'({30'h0, rom_word(4'd8)}));

    // Async reset during CAPTURE of digit 2.
    refresh = 1'b1; tick(1); refresh = 1'b0;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy",   64'(busy), 64'd0);
    chk("t6_glyphs", 64'(glyphs), 64'h0);
    chk("t6_done",   64'(done), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    fetch(lat);
    chk("t6_latency", 64'(lat), 64'd10);
    chk("t6_glyphs_after", 64'(glyphs), 64'h00000003FE);

    // Random traffic against the model, with rare mid-cycle resets.
    for (int k = 0; k < 4000; k++) begin
      score_inc = ($urandom % 3) == 0;
      score_clr = ($urandom % 60) == 0;
      refresh   = ($urandom % 8) == 0;
      if (($urandom % 900) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick(1);
    end
    score_inc = 1'b0; score_clr = 1'b0; refresh = 1'b0;
    tick(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
